// File: rtl/jb_dl_dfe_gain_pkg.sv
// Shared types, constants and arithmetic helpers for the DL DFE antenna gain stage.
package jb_dl_dfe_gain_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } seq_state_e;

  localparam int GAIN_FRAC = 14;
  localparam int GAIN_ONE  = 16384;
  localparam int CNT_W     = 16;

  // Clamp a signed value to the range of a signed word of the given width.
  function automatic logic signed [63:0] sat_p(input logic signed [63:0] value,
                                               input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

  // Event counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W - 1){1'b0}}, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/jb_dl_dfe_round_sat.sv
// One I or Q component: round the Q2.14-scaled product to nearest and saturate to PRECISION bits.
module jb_dl_dfe_round_sat
  import jb_dl_dfe_gain_pkg::*;
#(
  parameter int PRECISION = 16,
  parameter int PROD_W    = 33
) (
  input  logic signed [PROD_W-1:0]    prod,
  output logic signed [PRECISION-1:0] result,
  output logic                        sat
);

  localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1 << (GAIN_FRAC - 1));

  logic signed [PROD_W-1:0] shifted;
  logic signed [63:0]       wide;
  logic signed [63:0]       clamped;

  // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    shifted = (prod + HALF) >>> GAIN_FRAC;
    wide    = {{(64 - PROD_W){shifted[PROD_W-1]}}, shifted};
    clamped = sat_p(wide, PRECISION);
    result  = clamped[PRECISION-1:0];
    sat     = (clamped != wide);
  end

endmodule

// File: rtl/jb_dl_dfe_ant_gain_stage.sv
// Per-carrier antenna gain stage: round-robin antenna order check, per-antenna gain, per-frame event counts.
module jb_dl_dfe_ant_gain_stage
  import jb_dl_dfe_gain_pkg::*;
#(
  parameter int PRECISION  = 16,
  parameter int N_ANTENNAS = 4,
  parameter int GAIN_WIDTH = 16,
  parameter int LOCK_CNT   = 2
) (
  input  logic                             clk_1x,
  input  logic                             resetn,
  input  logic                             clk_x1en,
  input  logic                             dl_dfe_frm_mrkr,
  input  logic                             s_tvalid,
  input  logic [2*PRECISION-1:0]           s_tdata,
  input  logic [1:0]                       s_tuser,
  output logic                             s_tready,
  output logic                             m_tvalid,
  output logic [2*PRECISION-1:0]           m_tdata,
  output logic [1:0]                       m_tuser,
  input  logic [N_ANTENNAS*GAIN_WIDTH-1:0] ant_gain,
  input  logic                             gain_bypass,
  output logic                             seq_locked,
  output logic [CNT_W-1:0]                 seq_err_cnt,
  output logic [CNT_W-1:0]                 sat_cnt
);

  localparam int PROD_W = PRECISION + GAIN_WIDTH + 1;

  seq_state_e state;
  logic [1:0] expected;
  logic [7:0] rounds;

  logic accept, match, last_ant, seq_err_ev;

  logic                         s1_valid, s1_ok;
  logic [1:0]                   s1_user;
  logic signed [PRECISION-1:0]  s1_i, s1_q;
  logic [GAIN_WIDTH-1:0]        s1_gain;

  logic                         s2_valid, s2_ok;
  logic [1:0]                   s2_user;
  logic signed [PROD_W-1:0]     s2_prod_i, s2_prod_q;

  logic signed [PRECISION-1:0]  res_i, res_q;
  logic                         sat_i, sat_q, out_en;
  logic [1:0]                   sat_ev;
  logic [CNT_W-1:0]             run_err, run_sat, err_sum, sat_sum;

  assign s_tready   = 1'b1;
  assign seq_locked = (state == LOCKED);

  assign accept     = clk_x1en & s_tvalid;
  assign match      = (s_tuser == expected);
  assign last_ant   = (expected == 2'(N_ANTENNAS - 1));
  assign seq_err_ev = accept & (state == LOCKED) & ~match;

  // Order tracker: only an error while LOCKED is counted; a mismatch restarts the hunt.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_1x or negedge resetn) begin
    if (!resetn) begin
      state    <= HUNT;
      expected <= '0;
      rounds   <= '0;
    end else if (accept) begin
      unique case (state)
        HUNT: begin
          if (s_tuser == 2'd0) begin
            state    <= CHECK;
            expected <= 2'd1;
            rounds   <= '0;
          end
        end
        CHECK, LOCKED: begin
          if (match) begin
            expected <= last_ant ? 2'd0 : expected + 2'd1;
            if (state == CHECK && last_ant) begin
              rounds <= rounds + 8'd1;
              if (rounds + 8'd1 == 8'(LOCK_CNT)) state <= LOCKED;
            end
          end else if (s_tuser == 2'd0) begin
            state    <= CHECK;
            expected <= 2'd1;
            rounds   <= '0;
          end else begin
            state <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  jb_dl_dfe_round_sat #(.PRECISION(PRECISION), .PROD_W(PROD_W)) u_rs_i (
    .prod(s2_prod_i), .result(res_i), .sat(sat_i)
  );

  jb_dl_dfe_round_sat #(.PRECISION(PRECISION), .PROD_W(PROD_W)) u_rs_q (
    .prod(s2_prod_q), .result(res_q), .sat(sat_q)
  );

  assign out_en = s2_valid & s2_ok;
  assign sat_ev = {1'b0, sat_i & out_en} + {1'b0, sat_q & out_en};

  // Gain is captured with the sample, so a gain change never splits a sample.
  always_ff @(posedge clk_1x or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_ok     <= 1'b0;
      s1_user   <= '0;
      s1_i      <= '0;
      s1_q      <= '0;
      s1_gain   <= '0;
      s2_valid  <= 1'b0;
      s2_ok     <= 1'b0;
      s2_user   <= '0;
      s2_prod_i <= '0;
      s2_prod_q <= '0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tuser   <= '0;
    end else if (clk_x1en) begin
      s1_valid  <= s_tvalid;
      s1_ok     <= (state == LOCKED);
      s1_user   <= s_tuser;
      s1_i      <= s_tdata[PRECISION-1:0];
      s1_q      <= s_tdata[2*PRECISION-1:PRECISION];
      s1_gain   <= gain_bypass ? GAIN_WIDTH'(GAIN_ONE)
                               : ant_gain[int'(s_tuser)*GAIN_WIDTH +: GAIN_WIDTH];
      s2_valid  <= s1_valid;
      s2_ok     <= s1_ok;
      s2_user   <= s1_user;
      s2_prod_i <= PROD_W'(s1_i) * PROD_W'($signed({1'b0, s1_gain}));
      s2_prod_q <= PROD_W'(s1_q) * PROD_W'($signed({1'b0, s1_gain}));
      m_tvalid  <= out_en;
      m_tdata   <= out_en ? {res_q, res_i} : '0;
      m_tuser   <= out_en ? s2_user : 2'd0;
    end
  end

  assign err_sum = cnt_add(run_err, {1'b0, seq_err_ev});
  assign sat_sum = cnt_add(run_sat, sat_ev);

  // The frame marker reports the frame including events of its own strobe.
  always_ff @(posedge clk_1x or negedge resetn) begin
    if (!resetn) begin
      run_err     <= '0;
      run_sat     <= '0;
      seq_err_cnt <= '0;
      sat_cnt     <= '0;
    end else if (clk_x1en) begin
      if (dl_dfe_frm_mrkr) begin
        seq_err_cnt <= err_sum;
        sat_cnt     <= sat_sum;
        run_err     <= '0;
        run_sat     <= '0;
      end else begin
        run_err <= err_sum;
        run_sat <= sat_sum;
      end
    end
  end

endmodule

// File: tb/tb_jb_dl_dfe_ant_gain_stage.sv
// Randomized scoreboard bench for the antenna gain stage against a sequence/arithmetic reference model.
module tb_jb_dl_dfe_ant_gain_stage;

  localparam int N    = 4;
  localparam int LOCK = 2;

  logic        clk_1x = 1'b0;
  logic        resetn;
  logic        clk_x1en;
  logic        frm;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic [1:0]  s_tuser;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [1:0]  m_tuser;
  logic [63:0] ant_gain;
  logic        gain_bypass;
  logic        seq_locked;
  logic [15:0] seq_err_cnt;
  logic [15:0] sat_cnt;

  always #5 clk_1x = ~clk_1x;

  jb_dl_dfe_ant_gain_stage dut (
    .clk_1x(clk_1x), .resetn(resetn), .clk_x1en(clk_x1en), .dl_dfe_frm_mrkr(frm),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tuser(m_tuser), .ant_gain(ant_gain),
    .gain_bypass(gain_bypass), .seq_locked(seq_locked), .seq_err_cnt(seq_err_cnt),
    .sat_cnt(sat_cnt)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  user;
  } exp_t;

  exp_t exp_q[$];
  int   pending[int];
  int   checks = 0;
  int   failures = 0;
  int   strobe_idx = 0;
  int   mon_idx = 0;
  int   run = 0;
  int   m_run_err, m_run_sat, m_rep_err, m_rep_sat;
  int   gains[N];
  bit   bypass = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int apply_gain(input int x, input int g, inout int nsat);
    longint r;
    r = (longint'(x) * longint'(g) + 64'sd8192) >>> 14;
    if (r > 32767) begin
      nsat++;
      r = 32767;
    end else if (r < -32768) begin
      nsat++;
      r = -32768;
    end
    return int'(r);
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pending.delete();
    run = 0;
    m_run_err = 0;
    m_run_sat = 0;
    m_rep_err = 0;
    m_rep_sat = 0;
  endtask

  // One clock cycle of stimulus; the model advances on strobes only.
  task automatic drive(input bit en, input bit v, input logic [1:0] u,
                       input int i_val, input int q_val, input bit frm_in);
    int   sat_now;
    int   err;
    clk_x1en    = en;
    s_tvalid    = v;
    s_tuser     = u;
    s_tdata     = {q_val[15:0], i_val[15:0]};
    frm         = frm_in;
    gain_bypass = bypass;
    for (int k = 0; k < N; k++) ant_gain[k*16 +: 16] = gains[k][15:0];
    if (en) begin
      sat_now = 0;
      err     = 0;
      strobe_idx++;
      if (pending.exists(strobe_idx)) begin
        sat_now = pending[strobe_idx];
        pending.delete(strobe_idx);
      end
      if (v) begin
        bit   was_locked;
        bit   in_order;
        int   ns;
        int   g;
        int   oi;
        int   oq;
        exp_t e;
        was_locked = (run >= N * LOCK);
        in_order   = (run > 0) && (int'(u) == run % N);
        if (was_locked && !in_order) err = 1;
        if (in_order) run++;
        else if (u == 2'd0) run = 1;
        else run = 0;
        if (was_locked) begin
          ns = 0;
          g  = bypass ? 16384 : gains[u];
          oi = apply_gain(i_val, g, ns);
          oq = apply_gain(q_val, g, ns);
          e.due  = strobe_idx + 2;
          e.data = {oq[15:0], oi[15:0]};
          e.user = u;
          exp_q.push_back(e);
          if (ns > 0) begin
            if (pending.exists(strobe_idx + 2)) pending[strobe_idx + 2] += ns;
            else pending[strobe_idx + 2] = ns;
          end
        end
      end
      m_run_err = sat16(m_run_err + err);
      m_run_sat = sat16(m_run_sat + sat_now);
      if (frm_in) begin
        m_rep_err = m_run_err;
        m_rep_sat = m_run_sat;
        m_run_err = 0;
        m_run_sat = 0;
      end
    end
    @(posedge clk_1x);
    #1;
    check("seq_locked", seq_locked, (run >= N * LOCK) ? 1 : 0);
    check("seq_err_cnt", seq_err_cnt, m_rep_err);
    check("sat_cnt", sat_cnt, m_rep_sat);
  endtask

  task automatic send(input logic [1:0] u, input int i_val, input int q_val, input bit frm_in);
    drive(1'b1, 1'b1, u, i_val, q_val, frm_in);
  endtask

  task automatic idle(input int n, input bit frm_last);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 2'd0, 0, 0, frm_last && (k == n - 1));
  endtask

  task automatic lock_rounds(input int rounds);
    for (int r = 0; r < rounds; r++)
      for (int u = 0; u < N; u++) send(2'(u), rnd16(), rnd16(), 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a new output.
  initial begin
    bit          strobe;
    bit          last_valid;
    logic [31:0] last_data;
    exp_t        e;
    last_valid = 1'b0;
    last_data  = '0;
    forever begin
      @(posedge clk_1x);
      strobe = clk_x1en && resetn;
      if (strobe) mon_idx++;
      @(negedge clk_1x);
      if (!resetn) begin
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        last_valid = 1'b0;
        last_data  = '0;
      end else if (strobe) begin
        while (exp_q.size() > 0 && exp_q[0].due < mon_idx) begin
          check("output_latency", mon_idx, exp_q[0].due);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].due == mon_idx) begin
          e = exp_q.pop_front();
          check("m_tvalid", m_tvalid, 1);
          check("m_tdata", m_tdata, e.data);
          check("m_tuser", m_tuser, e.user);
          last_valid = 1'b1;
          last_data  = e.data;
        end else begin
          check("idle_m_tvalid", m_tvalid, 0);
          check("idle_m_tdata", m_tdata, 0);
          last_valid = 1'b0;
          last_data  = '0;
        end
      end else begin
        check("hold_m_tvalid", m_tvalid, last_valid);
        check("hold_m_tdata", m_tdata, last_data);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nxt;
    resetn   = 1'b0;
    clk_x1en = 1'b0;
    frm      = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
    ant_gain = '0;
    gain_bypass = 1'b0;
    for (int k = 0; k < N; k++) gains[k] = 16384;
    model_reset();

    // Reset state
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
    check("s_tready", s_tready, 1);
    #2 resetn = 1'b1;

    // 1: unity gain, lock after 8 in-order samples, data passes through
    lock_rounds(4);
    idle(4, 1'b0);

    // 2: half gain on antenna 1, rounding of +/-1001
    gains[1] = 8192;
    send(2'd0, rnd16(), rnd16(), 1'b0);
    send(2'd1, 1001, -1001, 1'b0);
    send(2'd2, rnd16(), rnd16(), 1'b0);
    send(2'd3, rnd16(), rnd16(), 1'b0);
    idle(3, 1'b1);

    // 3: double gain on antenna 2 saturates both components
    gains[2] = 32768;
    send(2'd0, 100, -100, 1'b0);
    send(2'd1, 200, -200, 1'b0);
    send(2'd2, 20000, -20000, 1'b0);
    send(2'd3, 300, -300, 1'b0);
    idle(3, 1'b1);
    idle(1, 1'b1);

    // 4: order error while locked, then relock
    for (int k = 0; k < N; k++) gains[k] = 16384;
    send(2'd0, rnd16(), rnd16(), 1'b0);
    send(2'd1, rnd16(), rnd16(), 1'b0);
    send(2'd3, rnd16(), rnd16(), 1'b0);
    send(2'd2, rnd16(), rnd16(), 1'b0);
    lock_rounds(3);
    idle(3, 1'b1);

    // 5: error on the frame-marker strobe, then strobe held low
    send(2'd0, rnd16(), rnd16(), 1'b0);
    send(2'd1, rnd16(), rnd16(), 1'b0);
    send(2'd3, rnd16(), rnd16(), 1'b1);
    idle(2, 1'b1);
    lock_rounds(3);
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 2'(k), rnd16(), rnd16(), 1'b1);
    idle(3, 1'b0);

    // Randomized traffic: order slips, gain and bypass changes, random frames
    nxt = 0;
    for (int c = 0; c < 3000; c++) begin
      bit          en;
      bit          v;
      logic [1:0]  u;
      if ($urandom_range(0, 49) == 0) gains[$urandom_range(0, N - 1)] = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 99) == 0) bypass = ~bypass;
      en = ($urandom_range(0, 9) < 8);
      v  = ($urandom_range(0, 7) != 0);
      u  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'(nxt);
      if (en && v) nxt = (int'(u) + 1) % N;
      drive(en, v, u, rnd16(), rnd16(), $urandom_range(0, 39) == 0);
    end
    bypass = 1'b0;
    idle(3, 1'b1);

    // 6: asynchronous reset mid-stream
    for (int k = 0; k < N; k++) gains[k] = 16384;
    lock_rounds(3);
    send(2'd0, 1234, -4321, 1'b0);
    #2 resetn = 1'b0;
    clk_x1en = 1'b0;
    model_reset();
    #1;
    check("arst_m_tvalid", m_tvalid, 0);
    check("arst_m_tdata", m_tdata, 0);
    check("arst_seq_locked", seq_locked, 0);
    check("arst_seq_err_cnt", seq_err_cnt, 0);
    check("arst_sat_cnt", sat_cnt, 0);
    drive(1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
    #2 resetn = 1'b1;
    lock_rounds(3);
    idle(3, 1'b1);

    // Saturated-event counter sticks at 0xFFFF
    for (int k = 0; k < N; k++) gains[k] = 65535;
    lock_rounds(2);
    for (int k = 0; k < 33000; k++) send(2'(k % N), 32767, -32768, 1'b0);
    idle(3, 1'b1);
    idle(1, 1'b1);

    idle(4, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jb_dl_dfe_ant_gain_stage.md
Name: jb_dl_dfe_ant_gain_stage

Overview:
- Per-carrier DL DFE stage directly downstream of the input stage.
- Consumes the antenna-interleaved AXI4-stream (tuser = antenna id) and checks that antennas arrive in strict round-robin order (0..N_ANTENNAS-1).
- Applies a per-antenna real digital gain with rounding and saturation.
- Reports sequence-error and saturation counts, latched per frame; one instance per carrier.

Parameters:
PRECISION, 16, bits per I/Q component
N_ANTENNAS, 4, interleaved antennas per carrier
GAIN_WIDTH, 16, unsigned gain word, Q2.14
LOCK_CNT, 2, complete in-order antenna rounds required to lock

Ports:
clk_1x  in  1  stage clock
resetn  in  1  asynchronous active-low reset
clk_x1en  in  1  sample strobe; all state advances only when 1
dl_dfe_frm_mrkr  in  1  frame marker, qualified by clk_x1en
s_tvalid  in  1  input sample valid
s_tdata  in  2*PRECISION  [P-1:0]=I, [2P-1:P]=Q, signed
s_tuser  in  2  antenna id
s_tready  out  1  constant 1
m_tvalid  out  1  output valid
m_tdata  out  2*PRECISION  gained sample, same packing
m_tuser  out  2  antenna id, delayed with data
ant_gain  in  N_ANTENNAS*GAIN_WIDTH  gain of antenna k at [k*G +: G]
gain_bypass  in  1  force unity gain
seq_locked  out  1  1 when FSM is LOCKED
seq_err_cnt  out  16  sequence errors in previous frame
sat_cnt  out  16  saturated components in previous frame

Behaviour:
- Clock and reset: one clock, clk_1x. resetn is asynchronous, active-low.
- Reset values: all outputs 0 (s_tready excepted), FSM HUNT, running counters 0, pipeline cleared. Reset mid-stream clears everything immediately; in-flight samples are dropped.
- Sample acceptance: a sample is accepted when clk_x1en & s_tvalid. With clk_x1en=0, every register holds.

Pipeline (latency 3 strobes, accepted sample to m_*):
- S1: register data, tuser, selected gain (gain_bypass → 16384), and flag ok = (FSM state == LOCKED before this sample's update).
- S2: signed P × unsigned G product, P+G+1 bits.
- S3: add 2^13, arithmetic shift right 14, saturate to [-2^(P-1), 2^(P-1)-1]. Each clamped component counts one sat event.
- Output: m_tvalid = valid & ok. When m_tvalid=0, m_tdata=0.
- Gain changes: gain is sampled at S1 per sample, so a change applies cleanly from the next accepted sample.
- Bypass: output is bit-exact to input.

Sequence FSM (advances on accepted samples only):
- HUNT: tuser==0 → CHECK, expected=1, rounds=0. Any other tuser → stay in HUNT.
- CHECK: tuser==expected → expected++. When expected wraps N-1→0, rounds++; rounds==LOCK_CNT → LOCKED. Mismatch → restart CHECK if tuser==0, else HUNT. Mismatch in CHECK does not count as an error.
- LOCKED: match → advance expected. Mismatch → seq_err++, then HUNT (or CHECK if tuser==0).

Counters:
- Running counters saturate at 0xFFFF.
- On clk_x1en & dl_dfe_frm_mrkr: seq_err_cnt/sat_cnt load running value plus any event in the same cycle; running counters clear to 0.

Decomposition:
- Package jb_dl_dfe_gain_pkg:
  - seq_state_e {HUNT, CHECK, LOCKED}
  - GAIN_FRAC=14, GAIN_ONE=16384, CNT_W=16
  - function sat_p(value, width)
- Sub-module jb_dl_dfe_round_sat: one component, product in → rounded/saturated out plus sat flag. Instantiated twice (I, Q).

Test Plan:
1. Reset, unity gain, tuser 0,1,2,3 repeated → seq_locked=1 after 8th accepted sample; 9th sample is first m_tvalid, 3 strobes later, data == input.
2. Locked, ant_gain[1]=8192, sample tuser=1 I=1001 Q=-1001 → m_tdata I=501, Q=-500, m_tuser=1, sat_cnt unchanged.
3. ant_gain[2]=32768, I=20000 Q=-20000 → I=32767, Q=-32768; frame marker next → sat_cnt=2, running cleared.
4. Locked, inject tuser 0,1,3 → seq_err_cnt=1 at next frame marker; seq_locked=0 from sample 3; m_tvalid=0 until relock after 8 in-order samples starting at tuser 0.
5. Sequence error and frm_mrkr on the same strobe → seq_err_cnt=1, next frame's count starts at 0; clk_x1en held low 10 cycles → all outputs unchanged.
6. resetn low mid-stream (async, off clock edge) → m_tvalid/m_tdata/seq_locked=0 immediately; after release, no output until relock.
